rx_frame_module: RTL and testbench

RX_FRAME_MODULE -- requirements
Module: rx_frame_module

---
 rtl/rx_frame_module.sv | 177 +++++++++++++++++
 tb/tb_rx_frame_module.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_module.sv
// rtl/rx_frame_module.sv - 8N1 asynchronous serial frame receiver
//
// Purpose:
//   Receives 8N1 frames on rx_pin (1 start bit, 8 data bits LSB first,
//   1 stop bit), sampling each bit at its nominal centre as timed from
//   the falling edge of the start bit. A correctly framed byte is
//   published on rx_data with a one-cycle rx_done_sig pulse. A byte whose
//   stop bit reads 0 gives a one-cycle rx_err_sig pulse instead. In that
//   case the receiver waits out the break condition before it accepts
//   another frame.
//
// Parameters:
//   BPS         clk cycles per serial bit (434 = 50 MHz at 115200 bps)
//
// Ports:
//   clk         system clock, rising-edge
//   rst_n       asynchronous active-low reset
//   rx_en_sig   receive enable; low forces IDLE and suppresses pulses
//   rx_pin      asynchronous serial input, idle high
//   rx_data     last correctly framed data byte
//   rx_done_sig one-cycle pulse: new byte on rx_data
//   rx_err_sig  one-cycle pulse: framing error (stop bit sampled 0)

module rx_frame_module #(
  parameter logic [12:0] BPS = 13'd434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_en_sig,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_done_sig,
  output logic       rx_err_sig
);

  // Sample points are reached when the timer reads the final count of
  // the interval. The timer restarts at 0 on every sample point, so a
  // full bit period spans the values 0..BPS-1.
  localparam logic [15:0] BPS_W     = {3'b000, BPS};
  localparam logic [15:0] FULL_LAST = BPS_W - 16'd1;
  localparam logic [15:0] HALF_LAST = (BPS_W >> 1) - 16'd1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t      state;
  logic        sync_1;
  logic        rx_sync;
  logic        rx_prev;
  logic [15:0] bit_timer;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;

  logic        fall_edge;
  logic        half_hit;
  logic        full_hit;

  // The synchronizer and rx_prev run regardless of rx_en_sig. A line
  // held low while the receiver is disabled therefore already has
  // rx_prev low when the receiver is enabled. It cannot be mistaken for
  // a start edge; only a later high-to-low transition can.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1  <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync_1  <= rx_pin;
      rx_sync <= sync_1;
      rx_prev <= rx_sync;
    end
  end

  assign fall_edge = rx_prev & ~rx_sync;
  assign half_hit  = (bit_timer == HALF_LAST);
  assign full_hit  = (bit_timer == FULL_LAST);

  // Frame FSM. Both pulses default low every cycle, which makes them
  // single-cycle by construction. They are set only in mutually
  // exclusive branches of the STOP state, so they never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_timer   <= 16'd0;
      bit_cnt     <= 3'd0;
      shift_reg   <= 8'h00;
      rx_data     <= 8'h00;
      rx_done_sig <= 1'b0;
      rx_err_sig  <= 1'b0;
    end else begin
      rx_done_sig <= 1'b0;
      rx_err_sig  <= 1'b0;

      if (!rx_en_sig) begin
        // Disable wins over everything, including a stop-bit sample
        // landing in this very cycle.
        state     <= IDLE;
        bit_timer <= 16'd0;
        bit_cnt   <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            bit_timer <= 16'd0;
            if (fall_edge) begin
              bit_cnt <= 3'd0;
              state   <= START;
            end
          end

          START: begin
            if (half_hit) begin
              bit_timer <= 16'd0;
              // Line back high at mid start bit: glitch, not a frame.
              state     <= rx_sync ? IDLE : DATA;
            end else begin
              bit_timer <= bit_timer + 16'd1;
            end
          end

          DATA: begin
            if (full_hit) begin
              bit_timer          <= 16'd0;
              shift_reg[bit_cnt] <= rx_sync;
              if (bit_cnt == 3'd7) begin
                bit_cnt <= 3'd0;
                state   <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              bit_timer <= bit_timer + 16'd1;
            end
          end

          STOP: begin
            if (full_hit) begin
              bit_timer <= 16'd0;
              if (rx_sync) begin
                rx_data     <= shift_reg;
                rx_done_sig <= 1'b1;
                // IDLE is entered right at the stop-bit centre, so a
                // start bit that follows immediately is still caught.
                state       <= IDLE;
              end else begin
                rx_err_sig  <= 1'b1;
                state       <= BREAK;
              end
            end else begin
              bit_timer <= bit_timer + 16'd1;
            end
          end

          BREAK: begin
            // Wait for the line to recover. Edges are ignored here, so
            // a long low level cannot be re-read as a start bit.
            bit_timer <= 16'd0;
            if (rx_sync) begin
              state <= IDLE;
            end
          end

          default: begin
            state     <= IDLE;
            bit_timer <= 16'd0;
            bit_cnt   <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_module.sv
// tb/tb_rx_frame_module.sv - directed scoreboard bench for rx_frame_module

module tb_rx_frame_module;

  localparam int BPS = 434;
  // Pin driven at the negedge after posedge n. Two synchronizer stages
  // follow, and the FSM enters START at posedge n+3. The stop-bit sample
  // edge is posedge n+3+BPS/2-1+9*BPS+1 = n+4126. The pulse is seen at
  // the negedge after that edge.
  localparam int PULSE_LAT = 3 + BPS / 2 + 9 * BPS - 1 + 1;

  typedef struct {
    logic [7:0] data;
    int         cyc;
    bit         is_err;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       rx_en_sig;
  logic       rx_pin;
  logic [7:0] rx_data;
  logic       rx_done_sig;
  logic       rx_err_sig;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  ev_t        exp_q[$];
  logic [7:0] last_data;

  rx_frame_module #(.BPS(13'd434)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_en_sig   (rx_en_sig),
    .rx_pin      (rx_pin),
    .rx_data     (rx_data),
    .rx_done_sig (rx_done_sig),
    .rx_err_sig  (rx_err_sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (rx_done_sig || rx_err_sig)) begin
      total++;
      assert (!(rx_done_sig && rx_err_sig)) else begin
        bad++;
        $error("FAIL pulse_excl done=%0b err=%0b expected not both", rx_done_sig, rx_err_sig);
      end
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_pulse cyc=%0d done=%0b err=%0b data=%02h expected no pulse",
               cyc, rx_done_sig, rx_err_sig, rx_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        assert (rx_err_sig === e.is_err) else begin
          bad++;
          $error("FAIL pulse_kind err=%0b expected %0b", rx_err_sig, e.is_err);
        end
        total++;
        assert (rx_data === e.data) else begin
          bad++;
          $error("FAIL pulse_data rx_data=%02h expected %02h", rx_data, e.data);
        end
        if (e.cyc >= 0) begin
          total++;
          assert (cyc === e.cyc) else begin
            bad++;
            $error("FAIL pulse_time cyc=%0d expected %0d", cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic drive_bits(input logic [9:0] frame, input int per, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rx_pin = frame[i];
      repeat (per) @(negedge clk);
    end
  endtask

  // Called at a negedge; queues the expected pulse, then drives the frame.
  task automatic send_frame(input logic [7:0] d, input int per, input logic stopb);
    ev_t e;
    e.is_err = !stopb;
    if (stopb) last_data = d;
    e.data   = last_data;
    e.cyc    = (per == BPS) ? cyc + PULSE_LAT : -1;
    exp_q.push_back(e);
    drive_bits({stopb, d, 1'b0}, per, 10);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL %s pending=%0d expected 0", tag, exp_q.size());
    end
  endtask

  task automatic check_data(input logic [7:0] want, input string tag);
    total++;
    assert (rx_data === want) else begin
      bad++;
      $error("FAIL %s rx_data=%02h expected %02h", tag, rx_data, want);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    rx_en_sig = 1'b1;
    rx_pin    = 1'b1;
    last_data = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    assert ({rx_data, rx_done_sig, rx_err_sig} === 10'b0) else begin
      bad++;
      $error("FAIL reset_state data=%02h done=%0b err=%0b expected 00/0/0",
             rx_data, rx_done_sig, rx_err_sig);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Basic frame.
    send_frame(8'hA5, BPS, 1'b1);
    wait_drain(1000, "drain_a5");
    check_data(8'hA5, "data_a5");

    // Framing error with a long break; rx_data keeps A5.
    send_frame(8'h3C, BPS, 1'b0);
    repeat (2000) @(negedge clk);
    check_data(8'hA5, "data_after_err");
    rx_pin = 1'b1;
    repeat (500) @(negedge clk);
    wait_drain(10, "drain_err");
    send_frame(8'h81, BPS, 1'b1);
    wait_drain(1000, "drain_81");

    // 100-cycle glitch gives no pulse; next frame still works.
    rx_pin = 1'b0;
    repeat (100) @(negedge clk);
    rx_pin = 1'b1;
    repeat (600) @(negedge clk);
    check_data(8'h81, "data_after_glitch");
    send_frame(8'h3C, BPS, 1'b1);
    wait_drain(1000, "drain_3c");

    // Back-to-back frames; each expected time is taken from its own start.
    send_frame(8'h00, BPS, 1'b1);
    send_frame(8'hFF, BPS, 1'b1);
    send_frame(8'h55, BPS, 1'b1);
    wait_drain(1000, "drain_b2b");
    check_data(8'h55, "data_b2b");

    // Enable dropped after bit 3; the rest of the line stays high.
    drive_bits({1'b1, 8'hF5, 1'b0}, BPS, 5);
    rx_pin    = 1'b1;
    rx_en_sig = 1'b0;
    repeat (20) @(negedge clk);
    rx_en_sig = 1'b1;
    repeat (5000) @(negedge clk);
    check_data(8'h55, "data_after_en_abort");
    send_frame(8'h5A, BPS, 1'b1);
    wait_drain(1000, "drain_5a_en");

    // Reset pulse after bit 3.
    drive_bits({1'b1, 8'hF5, 1'b0}, BPS, 5);
    rx_pin = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check_data(8'h00, "data_in_reset");
    last_data = 8'h00;
    rst_n = 1'b1;
    repeat (5000) @(negedge clk);
    check_data(8'h00, "data_after_rst_abort");
    send_frame(8'h5A, BPS, 1'b1);
    wait_drain(1000, "drain_5a_rst");

    // A line already low when the receiver is enabled does not start a frame.
    rx_en_sig = 1'b0;
    rx_pin    = 1'b0;
    repeat (50) @(negedge clk);
    rx_en_sig = 1'b1;
    repeat (300) @(negedge clk);
    rx_pin = 1'b1;
    repeat (100) @(negedge clk);
    check_data(8'h5A, "data_after_low_enable");

    // Bit-period margin of +/-8 cycles.
    send_frame(8'hC3, BPS + 8, 1'b1);
    wait_drain(1000, "drain_c3_slow");
    send_frame(8'hC3, BPS - 8, 1'b1);
    wait_drain(1000, "drain_c3_fast");
    check_data(8'hC3, "data_c3");

    repeat (100) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
